// File: rtl/ad9854_pkg.sv
// Shared definitions for the AD9854 parallel-port register scheduler:
// scheduler states, register addresses and byte-selection helper.
package ad9854_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WR_LO  = 3'd2,
    WR_HI  = 3'd3,
    UPDATE = 3'd4
  } state_t;

  // Frequency tuning word 1 occupies 0x04..0x09, MSB first.
  localparam logic [5:0] ADDR_FREQ_BASE = 6'h04;
  // OSK multiplier: upper nibble at 0x21, low byte at 0x22.
  localparam logic [5:0] ADDR_AMP_HI    = 6'h21;
  localparam logic [5:0] ADDR_AMP_LO    = 6'h22;

  localparam logic [2:0] FREQ_BYTES = 3'd6;
  localparam logic [2:0] AMP_BYTES  = 3'd2;

  // Byte idx of a 48-bit word, counting from the most significant byte.
  function automatic logic [7:0] freq_byte(input logic [47:0] w, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = w[47:40];
      3'd1:    b = w[39:32];
      3'd2:    b = w[31:24];
      3'd3:    b = w[23:16];
      3'd4:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ad9854_wr_timer.sv
// Loadable down-counter used to time the write-strobe low/high phases and
// the I/O-update pulse. done is high while the count is zero, so loading N-1
// yields a phase that lasts N cycles.
module ad9854_wr_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ad9854_reg_sched.sv
// Round-robin scheduler that writes frequency (6 bytes) or OSK amplitude
// (2 bytes) updates to an AD9854 over its parallel port, then pulses udclk.
//
// Handshake: freq_req/amp_req are levels held by the requester until the
// matching one-cycle ack; the word is sampled on the grant cycle (the cycle
// before the ack is seen) and request/word changes afterwards are ignored
// until the scheduler is back in IDLE.
import ad9854_pkg::*;

module ad9854_reg_sched #(
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int UD_CYC      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freq_req,
  input  logic [47:0] freq_word,
  output logic        freq_ack,
  input  logic        amp_req,
  input  logic [11:0] amp_word,
  output logic        amp_ack,
  output logic        busy,
  output logic [5:0]  pa,
  output logic [7:0]  pd,
  output logic        wr_n,
  output logic        udclk,
  output logic [2:0]  state_dbg
);

  localparam logic [7:0] LO_VAL = 8'(WR_LOW_CYC - 1);
  localparam logic [7:0] HI_VAL = 8'(WR_HIGH_CYC - 1);
  localparam logic [7:0] UD_VAL = 8'(UD_CYC - 1);

  state_t      state, next_state;
  logic [47:0] word;
  logic        is_amp;
  logic [2:0]  n_bytes;
  logic [2:0]  idx;
  logic        last_amp;
  logic        grant_freq, grant_amp;
  logic        tmr_load, tmr_done;
  logic [7:0]  tmr_val;
  logic        byte_next;

  ad9854_wr_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State register plus the transaction context captured at grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      word     <= '0;
      is_amp   <= 1'b0;
      n_bytes  <= '0;
      idx      <= '0;
      last_amp <= 1'b1;
      freq_ack <= 1'b0;
      amp_ack  <= 1'b0;
    end else begin
      state    <= next_state;
      freq_ack <= grant_freq;
      amp_ack  <= grant_amp;
      if (grant_freq) begin
        word     <= freq_word;
        is_amp   <= 1'b0;
        n_bytes  <= FREQ_BYTES;
        idx      <= '0;
        last_amp <= 1'b0;
      end else if (grant_amp) begin
        word     <= {36'd0, amp_word};
        is_amp   <= 1'b1;
        n_bytes  <= AMP_BYTES;
        idx      <= '0;
        last_amp <= 1'b1;
      end else if (byte_next) begin
        idx <= idx + 3'd1;
      end
    end
  end

  // Next-state logic: arbitration in IDLE, phase sequencing via the timer.
  always_comb begin
    next_state = state;
    grant_freq = 1'b0;
    grant_amp  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    byte_next  = 1'b0;
    case (state)
      IDLE: begin
        if (freq_req && (!amp_req || last_amp)) begin
          grant_freq = 1'b1;
          next_state = SETUP;
        end else if (amp_req) begin
          grant_amp  = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        tmr_load   = 1'b1;
        tmr_val    = LO_VAL;
        next_state = WR_LO;
      end
      WR_LO: begin
        if (tmr_done) begin
          tmr_load   = 1'b1;
          tmr_val    = HI_VAL;
          next_state = WR_HI;
        end
      end
      WR_HI: begin
        if (tmr_done) begin
          if (idx == n_bytes - 3'd1) begin
            tmr_load   = 1'b1;
            tmr_val    = UD_VAL;
            next_state = UPDATE;
          end else begin
            byte_next  = 1'b1;
            next_state = SETUP;
          end
        end
      end
      UPDATE: begin
        if (tmr_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Port outputs decoded from state and the current byte index; zero in IDLE.
  always_comb begin
    pa    = '0;
    pd    = '0;
    busy  = (state != IDLE);
    wr_n  = (state != WR_LO);
    udclk = (state == UPDATE);
    if (state != IDLE) begin
      if (is_amp) begin
        pa = (idx == 3'd0) ? ADDR_AMP_HI : ADDR_AMP_LO;
        pd = (idx == 3'd0) ? {4'b0000, word[11:8]} : word[7:0];
      end else begin
        pa = ADDR_FREQ_BASE + {3'b000, idx};
        pd = freq_byte(word, idx);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ad9854_reg_sched.sv
// Directed bench for ad9854_reg_sched: default-parameter instance (a_*) and a
// WR_LOW_CYC=1 / WR_HIGH_CYC=3 instance (b_*). Outputs are sampled and inputs
// driven on the falling clock edge.
module tb_ad9854_reg_sched;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_freq_req, a_amp_req, a_freq_ack, a_amp_ack, a_busy, a_wr_n, a_udclk;
  logic [47:0] a_freq_word;
  logic [11:0] a_amp_word;
  logic [5:0]  a_pa;
  logic [7:0]  a_pd;
  logic [2:0]  a_state;

  logic        b_freq_req, b_amp_req, b_freq_ack, b_amp_ack, b_busy, b_wr_n, b_udclk;
  logic [47:0] b_freq_word;
  logic [11:0] b_amp_word;
  logic [5:0]  b_pa;
  logic [7:0]  b_pd;
  logic [2:0]  b_state;

  // Monitor view of whichever instance is under test.
  logic sel;
  logic        m_busy, m_wr_n, m_udclk, m_freq_ack, m_amp_ack;
  logic [5:0]  m_pa;
  logic [7:0]  m_pd;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_wr_n     = sel ? b_wr_n     : a_wr_n;
  assign m_udclk    = sel ? b_udclk    : a_udclk;
  assign m_freq_ack = sel ? b_freq_ack : a_freq_ack;
  assign m_amp_ack  = sel ? b_amp_ack  : a_amp_ack;
  assign m_pa       = sel ? b_pa       : a_pa;
  assign m_pd       = sel ? b_pd       : a_pd;

  ad9854_reg_sched dut_a (
    .clk(clk), .rst_n(rst_n),
    .freq_req(a_freq_req), .freq_word(a_freq_word), .freq_ack(a_freq_ack),
    .amp_req(a_amp_req), .amp_word(a_amp_word), .amp_ack(a_amp_ack),
    .busy(a_busy), .pa(a_pa), .pd(a_pd), .wr_n(a_wr_n), .udclk(a_udclk),
    .state_dbg(a_state)
  );

  ad9854_reg_sched #(.WR_LOW_CYC(1), .WR_HIGH_CYC(3), .UD_CYC(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .freq_req(b_freq_req), .freq_word(b_freq_word), .freq_ack(b_freq_ack),
    .amp_req(b_amp_req), .amp_word(b_amp_word), .amp_ack(b_amp_ack),
    .busy(b_busy), .pa(b_pa), .pd(b_pd), .wr_n(b_wr_n), .udclk(b_udclk),
    .state_dbg(b_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [13:0] exp_q[$];
  logic [13:0] got_q[$];

  int nbusy, nud, min_lo, max_lo, hold_err;
  logic [1:0] acks;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for either ack of the selected instance; returns {freq,amp}.
  task automatic wait_ack(output logic [1:0] a);
    a = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_freq_ack || m_amp_ack) begin
        a = {m_freq_ack, m_amp_ack};
        break;
      end
    end
  endtask

  // Called on the first busy cycle; walks the transaction until busy drops,
  // logging each write's {pa,pd} and the length of every wr_n-low run.
  task automatic collect();
    logic       prev_wr;
    int         lo_run;
    logic [13:0] cur;
    prev_wr = 1'b1; lo_run = 0; cur = '0;
    nbusy = 0; nud = 0; min_lo = 999; max_lo = 0; hold_err = 0;
    got_q.delete();
    for (int c = 0; c < 200; c++) begin
      if (!m_busy) break;
      nbusy++;
      if (m_udclk) nud++;
      if (!m_wr_n) begin
        if (prev_wr) begin
          cur = {m_pa, m_pd};
          got_q.push_back(cur);
        end else if ({m_pa, m_pd} != cur) begin
          hold_err++;
        end
        lo_run++;
      end else if (!prev_wr) begin
        if ({m_pa, m_pd} != cur) hold_err++;
        if (lo_run < min_lo) min_lo = lo_run;
        if (lo_run > max_lo) max_lo = lo_run;
        lo_run = 0;
      end
      prev_wr = m_wr_n;
      @(negedge clk);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_wr"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    sel = 1'b0;
    rst_n = 1'b0;
    a_freq_req = 0; a_amp_req = 0; a_freq_word = '0; a_amp_word = '0;
    b_freq_req = 0; b_amp_req = 0; b_freq_word = '0; b_amp_word = '0;

    // Reset state
    do_reset();
    check("rst_busy",  a_busy, 0);
    check("rst_wr_n",  a_wr_n, 1);
    check("rst_udclk", a_udclk, 0);
    check("rst_pa",    a_pa, 0);
    check("rst_pd",    a_pd, 0);
    check("rst_acks",  {a_freq_ack, a_amp_ack}, 0);
    check("rst_state", a_state, 3'd0);

    // Frequency write 0x123456789ABC
    a_freq_word = 48'h1234_5678_9ABC;
    a_freq_req = 1;
    wait_ack(acks);
    check("f1_ack", acks, 2'b10);
    a_freq_req = 0;
    collect();
    check("f1_busy", nbusy, 34);
    check("f1_ud", nud, 4);
    check("f1_lo_min", min_lo, 2);
    check("f1_lo_max", max_lo, 2);
    check("f1_hold", hold_err, 0);
    exp_q = '{{6'h04, 8'h12}, {6'h05, 8'h34}, {6'h06, 8'h56},
              {6'h07, 8'h78}, {6'h08, 8'h9A}, {6'h09, 8'hBC}};
    check_writes("f1");
    check("f1_idle_pa", {a_pa, a_pd, a_wr_n, a_udclk}, {6'h00, 8'h00, 1'b1, 1'b0});

    // Amplitude write 0xFFF
    a_amp_word = 12'hFFF;
    a_amp_req = 1;
    wait_ack(acks);
    check("a1_ack", acks, 2'b01);
    a_amp_req = 0;
    collect();
    check("a1_busy", nbusy, 14);
    check("a1_ud", nud, 4);
    exp_q = '{{6'h21, 8'h0F}, {6'h22, 8'hFF}};
    check_writes("a1");

    // Word changed after ack: bytes follow the value at grant
    a_freq_word = 48'hA5A5_0F0F_C3C3;
    a_freq_req = 1;
    wait_ack(acks);
    check("f2_ack", acks, 2'b10);
    a_freq_req = 0;
    a_freq_word = 48'h0000_0000_0000;
    collect();
    check("f2_busy", nbusy, 34);
    exp_q = '{{6'h04, 8'hA5}, {6'h05, 8'hA5}, {6'h06, 8'h0F},
              {6'h07, 8'h0F}, {6'h08, 8'hC3}, {6'h09, 8'hC3}};
    check_writes("f2");

    // Simultaneous requests after reset: frequency first, amplitude 1 cycle after UPDATE
    do_reset();
    a_freq_word = 48'h0102_0304_0506;
    a_amp_word = 12'h3C7;
    a_freq_req = 1; a_amp_req = 1;
    wait_ack(acks);
    check("rr1_ack", acks, 2'b10);
    a_freq_req = 0;
    collect();
    check("rr1_busy", nbusy, 34);
    check("rr1_gap_idle", {a_busy, a_freq_ack, a_amp_ack}, 3'b000);
    @(negedge clk);
    check("rr1_amp_ack", {a_freq_ack, a_amp_ack}, 2'b01);
    a_amp_req = 0;
    collect();
    check("rr1_amp_busy", nbusy, 14);
    exp_q = '{{6'h21, 8'h03}, {6'h22, 8'hC7}};
    check_writes("rr1");

    // Frequency-only, then both again: amplitude must win this time
    a_freq_req = 1;
    wait_ack(acks);
    check("rr2_f_ack", acks, 2'b10);
    a_freq_req = 0;
    collect();
    a_freq_req = 1; a_amp_req = 1;
    wait_ack(acks);
    check("rr2_ack", acks, 2'b01);
    a_amp_req = 0;
    collect();
    check("rr2_amp_busy", nbusy, 14);
    @(negedge clk);
    check("rr2_freq_ack", {a_freq_ack, a_amp_ack}, 2'b10);
    a_freq_req = 0;
    collect();
    check("rr2_freq_busy", nbusy, 34);

    // Reset during the third frequency byte
    a_freq_word = 48'h1234_5678_9ABC;
    a_freq_req = 1;
    wait_ack(acks);
    a_freq_req = 0;
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (a_pa == 6'h06 && !a_wr_n) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("mr_third_byte", found, 1'b1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_out", {a_wr_n, a_udclk, a_busy, a_pa, a_pd}, {1'b1, 1'b0, 1'b0, 6'h00, 8'h00});
    check("mr_acks", {a_freq_ack, a_amp_ack}, 2'b00);
    rst_n = 1'b1;
    begin
      int activity;
      activity = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!a_wr_n || a_busy || a_udclk) activity++;
      end
      check("mr_quiet", activity, 0);
    end

    // Alternate timing instance: WR_LOW_CYC=1, WR_HIGH_CYC=3
    sel = 1'b1;
    b_freq_word = 48'hFEDC_BA98_7654;
    b_freq_req = 1;
    wait_ack(acks);
    check("b_ack", acks, 2'b10);
    b_freq_req = 0;
    collect();
    check("b_busy", nbusy, 34);
    check("b_lo_min", min_lo, 1);
    check("b_lo_max", max_lo, 1);
    check("b_ud", nud, 4);
    exp_q = '{{6'h04, 8'hFE}, {6'h05, 8'hDC}, {6'h06, 8'hBA},
              {6'h07, 8'h98}, {6'h08, 8'h76}, {6'h09, 8'h54}};
    check_writes("b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
